// File: rtl/sap_ctrl_seq.sv
// -----------------------------------------------------------------------------
// sap_ctrl_seq
// Controller-sequencer for the 8-bit microcomputer. It sits directly after the
// 6-bit T-state ring counter. It decodes the one-hot T-state and the IR opcode
// into the active-high control word. It also ends each instruction early
// through the ring counter's set input, and parks the machine on HLT.
//
// Ports:
//   clk          system clock; state updates on posedge (ring moves on negedge)
//   clear        synchronous active-high reset
//   t_state      one-hot T-state, T1 = 6'b100000 ... T6 = 6'b000001
//   ir_opcode    upper nibble of the IR, valid from T4 onward
//   ctrl         control word {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
//   ring_set     forces the ring counter back to T1 at the next negedge
//   hlt          machine halted
//   instr_count  retired-instruction counter, wraps modulo 2^CNT_W
//   illegal_op   sticky: an undefined opcode was executed
//   ring_fault   sticky: a non-one-hot t_state was seen while running
// -----------------------------------------------------------------------------
module sap_ctrl_seq #(
    parameter int         CNT_W  = 8,
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [5:0]       t_state,
    input  logic [3:0]       ir_opcode,
    output logic [11:0]      ctrl,
    output logic             ring_set,
    output logic             hlt,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal_op,
    output logic             ring_fault
);

    typedef enum logic [1:0] {
        RST_WAIT,
        RUN,
        HALTED
    } state_t;

    localparam logic [5:0] T1 = 6'b100000;
    localparam logic [5:0] T2 = 6'b010000;
    localparam logic [5:0] T3 = 6'b001000;
    localparam logic [5:0] T4 = 6'b000100;
    localparam logic [5:0] T5 = 6'b000010;
    localparam logic [5:0] T6 = 6'b000001;

    // Each control signal is one bit of the control word.
    localparam logic [11:0] C_CP = 12'b1000_0000_0000;
    localparam logic [11:0] C_EP = 12'b0100_0000_0000;
    localparam logic [11:0] C_LM = 12'b0010_0000_0000;
    localparam logic [11:0] C_CE = 12'b0001_0000_0000;
    localparam logic [11:0] C_LI = 12'b0000_1000_0000;
    localparam logic [11:0] C_EI = 12'b0000_0100_0000;
    localparam logic [11:0] C_LA = 12'b0000_0010_0000;
    localparam logic [11:0] C_EA = 12'b0000_0001_0000;
    localparam logic [11:0] C_SU = 12'b0000_0000_1000;
    localparam logic [11:0] C_EU = 12'b0000_0000_0100;
    localparam logic [11:0] C_LB = 12'b0000_0000_0010;
    localparam logic [11:0] C_LO = 12'b0000_0000_0001;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             illegal_q, illegal_d;
    logic             fault_q, fault_d;

    logic oneHot;
    logic isArith;
    logic knownOp;
    logic endInstr;
    logic haltExec;
    logic illegalExec;

    // Decode the control word from the state, T-state and opcode.
    // ring_set defaults high because it must be high in every case except the
    // non-final T-states of a running instruction. A T5/T6 that shows up after
    // a short instruction has already ended is treated the same way: no
    // control signals and a request to reload T1.
    always_comb begin
        ctrl        = '0;
        ring_set    = 1'b1;
        hlt         = 1'b0;
        endInstr    = 1'b0;
        haltExec    = 1'b0;
        illegalExec = 1'b0;
        oneHot      = (t_state != 6'd0) && ((t_state & (t_state - 6'd1)) == 6'd0);
        isArith     = (ir_opcode == OP_ADD) || (ir_opcode == OP_SUB);
        knownOp     = (ir_opcode == OP_LDA) || isArith ||
                      (ir_opcode == OP_OUT) || (ir_opcode == OP_HLT);

        case (state_q)
            HALTED: hlt = 1'b1;
            RUN: begin
                if (oneHot) begin
                    ring_set = 1'b0;
                    case (t_state)
                        T1: ctrl = C_EP | C_LM;
                        T2: ctrl = C_CP;
                        T3: ctrl = C_CE | C_LI;
                        T4: begin
                            if ((ir_opcode == OP_LDA) || isArith) begin
                                ctrl = C_EI | C_LM;
                            end else begin
                                endInstr = 1'b1;
                                if (ir_opcode == OP_OUT) ctrl = C_EA | C_LO;
                                haltExec    = (ir_opcode == OP_HLT);
                                illegalExec = !knownOp;
                            end
                        end
                        T5: begin
                            if (ir_opcode == OP_LDA) begin
                                ctrl     = C_CE | C_LA;
                                endInstr = 1'b1;
                            end else if (isArith) begin
                                ctrl = C_CE | C_LB;
                            end else begin
                                ring_set = 1'b1;
                            end
                        end
                        T6: begin
                            if (isArith) begin
                                ctrl     = C_EU | C_LA | ((ir_opcode == OP_SUB) ? C_SU : 12'd0);
                                endInstr = 1'b1;
                            end else begin
                                ring_set = 1'b1;
                            end
                        end
                        default: ring_set = 1'b1;
                    endcase
                    if (endInstr) ring_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Work out the next state and the counter/flag updates.
    // A non-one-hot T-state raises the fault flag. The controller stays in RUN
    // and picks up decoding again when the ring comes back to T1.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        case (state_q)
            RST_WAIT: begin
                if (t_state == T1) state_d = RUN;
            end
            RUN: begin
                if (!oneHot)     fault_d   = 1'b1;
                if (endInstr)    count_d   = count_q + CNT_W'(1);
                if (haltExec)    state_d   = HALTED;
                if (illegalExec) illegal_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State register. clear takes priority over every other update.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= RST_WAIT;
            count_q   <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
        end
    end

    assign instr_count = count_q;
    assign illegal_op  = illegal_q;
    assign ring_fault  = fault_q;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_sap_ctrl_seq
// Bench for the controller-sequencer. A ring-counter model drives t_state on
// negedge. Each cycle the stimulus side runs an instruction-level reference
// model and queues the expected outputs for that cycle. A separate monitor
// pops the queue and compares the outputs just before the next posedge.
// -----------------------------------------------------------------------------
module tb_sap_ctrl_seq;

    localparam int CNT_W = 8;
    localparam logic [5:0] T1 = 6'b100000;

    logic             clk = 1'b0;
    logic             clear;
    logic [5:0]       t_state;
    logic [3:0]       ir_opcode;
    logic [11:0]      ctrl;
    logic             ring_set;
    logic             hlt;
    logic [CNT_W-1:0] instr_count;
    logic             illegal_op;
    logic             ring_fault;

    typedef struct packed {
        logic [11:0]      ctrl;
        logic             rs;
        logic             hlt;
        logic [CNT_W-1:0] cnt;
        logic             ill;
        logic             flt;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: 0 = waiting after reset, 1 = running, 2 = halted.
    int         mMode  = 0;
    int         mCount = 0;
    bit         mIll   = 1'b0;
    bit         mFlt   = 1'b0;
    logic [5:0] ring   = 6'b000100;
    bit         rsPrev = 1'b0;
    logic [3:0] opReg  = 4'h0;
    logic [3:0] progQ[$];
    bit         allowHlt = 1'b0;

    always #5 clk = ~clk;

    sap_ctrl_seq #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .clear      (clear),
        .t_state    (t_state),
        .ir_opcode  (ir_opcode),
        .ctrl       (ctrl),
        .ring_set   (ring_set),
        .hlt        (hlt),
        .instr_count(instr_count),
        .illegal_op (illegal_op),
        .ring_fault (ring_fault)
    );

    // Number of execute T-states (from T4) for each opcode.
    function automatic int opLen(input logic [3:0] op);
        case (op)
            4'h0:       return 2;
            4'h1, 4'h2: return 3;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [11:0] fetchWord(input int i);
        case (i)
            0:       return 12'h600;   // ep,lm
            1:       return 12'h800;   // cp
            default: return 12'h180;   // ce,li
        endcase
    endfunction

    function automatic logic [11:0] execWord(input logic [3:0] op, input int e);
        if (op == 4'h0) return (e == 0) ? 12'h240 : 12'h120;
        if (op == 4'h1 || op == 4'h2) begin
            if (e == 0) return 12'h240;
            if (e == 1) return 12'h102;
            return (op == 4'h2) ? 12'h02C : 12'h024;
        end
        if (op == 4'hE) return 12'h011;
        return 12'h000;
    endfunction

    function automatic int tIndex(input logic [5:0] t);
        for (int i = 0; i < 6; i++) if (t[5-i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] pickOp();
        int r;
        if (progQ.size() > 0) return progQ.pop_front();
        r = $urandom_range(0, 15);
        if (!allowHlt && r == 15) r = 0;
        return r[3:0];
    endfunction

    // Run one clock: move the ring, drive the inputs, queue the expected
    // outputs, and then step the model across the coming posedge.
    task automatic applyStimulus(input bit clr, input bit frc, input logic [5:0] fval);
        exp_t       e;
        logic [5:0] t;
        int         idx;
        int         step;
        int         len;
        bit         oneHot;
        @(negedge clk);
        ring = rsPrev ? T1 : (ring >> 1);
        t    = frc ? fval : ring;
        if (t == T1) opReg = pickOp();
        t_state   = t;
        ir_opcode = opReg;
        clear     = clr;

        oneHot = ($countones(t) == 1);
        idx    = tIndex(t);
        step   = idx - 3;
        len    = opLen(opReg);
        e      = '0;
        e.rs   = 1'b1;
        e.cnt  = mCount[CNT_W-1:0];
        e.ill  = mIll;
        e.flt  = mFlt;
        if (mMode == 2) begin
            e.hlt = 1'b1;
        end else if (mMode == 1 && oneHot) begin
            if (idx < 3) begin
                e.ctrl = fetchWord(idx);
                e.rs   = 1'b0;
            end else if (step < len) begin
                e.ctrl = execWord(opReg, step);
                e.rs   = (step == len - 1);
            end
        end
        expQ.push_back(e);
        rsPrev = e.rs;

        if (clr) begin
            mMode = 0; mCount = 0; mIll = 1'b0; mFlt = 1'b0;
        end else if (mMode == 0) begin
            if (t == T1) mMode = 1;
        end else if (mMode == 1) begin
            if (!oneHot) begin
                mFlt = 1'b1;
            end else if (idx >= 3 && step == len - 1) begin
                mCount = (mCount + 1) % (1 << CNT_W);
                if (opReg == 4'hF) mMode = 2;
                if (!(opReg inside {4'h0, 4'h1, 4'h2, 4'hE, 4'hF})) mIll = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Monitor: once per cycle, sample just before the posedge and compare
    // against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("ctrl",        32'(ctrl),        32'(e.ctrl));
                checkOutput("ring_set",    32'(ring_set),    32'(e.rs));
                checkOutput("hlt",         32'(hlt),         32'(e.hlt));
                checkOutput("instr_count", 32'(instr_count), 32'(e.cnt));
                checkOutput("illegal_op",  32'(illegal_op),  32'(e.ill));
                checkOutput("ring_fault",  32'(ring_fault),  32'(e.flt));
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized instruction streams.
    initial begin
        bit found;
        int haltCycles;
        clear     = 1'b1;
        t_state   = 6'b000010;
        ir_opcode = 4'h0;
        @(posedge clk);
        $display("[TB] reset and directed program");
        applyStimulus(1'b1, 1'b0, 6'd0);
        applyStimulus(1'b1, 1'b0, 6'd0);
        progQ = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h5, 4'h0};
        for (int i = 0; i < 34; i++) applyStimulus(1'b0, 1'b0, 6'd0);

        $display("[TB] forced ring faults");
        applyStimulus(1'b0, 1'b0, 6'd0);
        applyStimulus(1'b0, 1'b0, 6'd0);
        applyStimulus(1'b0, 1'b1, 6'b000000);
        applyStimulus(1'b0, 1'b1, 6'b110000);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 6'd0);

        $display("[TB] clear during ADD T5");
        progQ.push_back(4'h1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (!rsPrev && (ring >> 1) == 6'b000010 && opReg == 4'h1) begin
                applyStimulus(1'b1, 1'b0, 6'd0);
                found = 1'b1;
            end else begin
                applyStimulus(1'b0, 1'b0, 6'd0);
            end
        end
        checkOutput("reach_add_t5", 32'(found), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 6'd0);

        $display("[TB] halt after two instructions");
        applyStimulus(1'b1, 1'b0, 6'd0);
        progQ = '{4'h0, 4'hE, 4'hF};
        for (int i = 0; i < 45; i++) applyStimulus(1'b0, 1'b0, 6'd0);
        applyStimulus(1'b1, 1'b0, 6'd0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 6'd0);

        $display("[TB] random stream without halt");
        allowHlt = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0)
                applyStimulus(1'b0, 1'b1, 6'($urandom_range(0, 63)));
            else
                applyStimulus(1'b0, 1'b0, 6'd0);
        end

        $display("[TB] random stream with halt and clear");
        allowHlt   = 1'b1;
        haltCycles = 0;
        for (int i = 0; i < 1500; i++) begin
            haltCycles = (mMode == 2) ? haltCycles + 1 : 0;
            if (haltCycles > 20 || $urandom_range(0, 299) == 0)
                applyStimulus(1'b1, 1'b0, 6'd0);
            else if ($urandom_range(0, 99) == 0)
                applyStimulus(1'b0, 1'b1, 6'($urandom_range(0, 63)));
            else
                applyStimulus(1'b0, 1'b0, 6'd0);
        end

        @(negedge clk);
        @(negedge clk);
        #3;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
